// File: rtl/cache_ctrl_2way.sv
// rtl/cache_ctrl_2way.sv - request-side controller for a 2-way set-associative write-back cache
module cache_ctrl_2way #(
    parameter  int NUM_SETS = 128,
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int TAG_W    = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [IDX_W-1:0]  lru_index,
    output logic              lru_update_en,
    output logic              lru_new_mru_way,
    input  logic              lru_victim_way
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;

    state_t              state;
    logic                req_we;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [DATA_W-1:0]   req_wdata;
    logic                victim_q;

    logic [TAG_W-1:0]    tag_arr  [2][NUM_SETS];
    logic [DATA_W-1:0]   data_arr [2][NUM_SETS];
    logic [NUM_SETS-1:0] valid_q  [2];
    logic [NUM_SETS-1:0] dirty_q  [2];

    logic [1:0] way_hit;
    logic       hit;
    logic       hit_way;
    logic       victim_c;
    logic       victim_dirty;
    logic       refill_done;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_req_addr[1:0];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = valid_q[w][req_idx] && (tag_arr[w][req_idx] == req_tag);
        end
    end

    // Way 0 wins if both ways ever claim the tag.
    assign hit          = |way_hit;
    assign hit_way      = ~way_hit[0];
    assign victim_c     = !valid_q[0][req_idx] ? 1'b0 :
                          !valid_q[1][req_idx] ? 1'b1 : lru_victim_way;
    assign victim_dirty = valid_q[victim_c][req_idx] && dirty_q[victim_c][req_idx];
    assign refill_done  = (state == REFILL_WAIT) && mem_resp_valid;

    // The tracker is combinational on the index, so the strobe must land in the deciding cycle.
    assign lru_index       = (state == IDLE) ? cpu_req_addr[IDX_W+1:2] : req_idx;
    assign lru_update_en   = ((state == LOOKUP) && hit) || refill_done;
    assign lru_new_mru_way = (state == LOOKUP)      ? hit_way :
                             (state == REFILL_WAIT) ? victim_q : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            req_we         <= 1'b0;
            req_tag        <= '0;
            req_idx        <= '0;
            req_wdata      <= '0;
            victim_q       <= 1'b0;
            valid_q[0]     <= '0;
            valid_q[1]     <= '0;
            dirty_q[0]     <= '0;
            dirty_q[1]     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_we        <= cpu_req_we;
                        req_tag       <= cpu_req_addr[ADDR_W-1:IDX_W+2];
                        req_idx       <= cpu_req_addr[IDX_W+1:2];
                        req_wdata     <= cpu_req_wdata;
                        cpu_req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (req_we) dirty_q[hit_way][req_idx] <= 1'b1;
                        cpu_resp_rdata <= req_we ? req_wdata : data_arr[hit_way][req_idx];
                        cpu_resp_valid <= 1'b1;
                        state          <= RESPOND;
                    end else begin
                        victim_q      <= victim_c;
                        mem_req_valid <= 1'b1;
                        if (victim_dirty) begin
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= {tag_arr[victim_c][req_idx], req_idx, 2'b00};
                            mem_req_wdata <= data_arr[victim_c][req_idx];
                            state         <= WRITEBACK;
                        end else begin
                            mem_req_we   <= 1'b0;
                            mem_req_addr <= {req_tag, req_idx, 2'b00};
                            state        <= REFILL_REQ;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        mem_req_we   <= 1'b0;
                        mem_req_addr <= {req_tag, req_idx, 2'b00};
                        state        <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[victim_q][req_idx] <= 1'b1;
                        dirty_q[victim_q][req_idx] <= req_we;
                        cpu_resp_rdata             <= req_we ? req_wdata : mem_resp_rdata;
                        cpu_resp_valid             <= 1'b1;
                        state                      <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == LOOKUP) && hit && req_we) begin
            data_arr[hit_way][req_idx] <= req_wdata;
        end
        if (refill_done) begin
            tag_arr[victim_q][req_idx]  <= req_tag;
            data_arr[victim_q][req_idx] <= req_we ? req_wdata : mem_resp_rdata;
        end
    end

endmodule

// File: doc/cache_ctrl_2way.md
# cache_ctrl_2way

Request-side controller for the 2-way set-associative cache. It accepts CPU load/store requests, holds the tag, valid, dirty and data arrays, and resolves hit or miss. On a miss it writes back a dirty victim and refills from memory. It drives the per-set LRU tracker: it supplies index, update strobe and new-MRU way, and consumes the victim way. Lines are one data word; the cache is write-back and write-allocate.

## Interface
- NUM_SETS, 128, sets (power of 2); IDX_W = $clog2(NUM_SETS)
- ADDR_W, 32, byte address width; index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2]
- DATA_W, 32, word width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req_valid / cpu_req_ready  in / out  1  request handshake
- cpu_req_we  in  1  1 = store
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_req_wdata  in  DATA_W  store data
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  DATA_W  load data; store data echoed for stores
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_we  out  1  1 = writeback
- mem_req_addr  out  ADDR_W  word-aligned line address
- mem_req_wdata  out  DATA_W  writeback data
- mem_resp_valid  in  1  refill data valid
- mem_resp_rdata  in  DATA_W  refill data
- lru_index  out  IDX_W  set index for the LRU tracker
- lru_update_en  out  1  LRU update strobe
- lru_new_mru_way  out  1  way just accessed
- lru_victim_way  in  1  LRU way of lru_index (combinational from tracker)

## Operation
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: cpu_req_ready = 1.
  - On valid&&ready, latch we/addr/wdata and go to LOOKUP.
  - The CPU need not hold the request after acceptance.
- LOOKUP: compare the latched tag against both ways, qualified by valid.
  - Hit in way w: pulse lru_update_en with lru_new_mru_way = w. A store writes data[w] and sets dirty[w]. Go to RESPOND.
  - Both ways hitting cannot occur; if it does, way 0 wins.
  - Miss: victim selection is, in priority order, invalid way 0, then invalid way 1, else lru_victim_way. Latch the victim.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL_REQ.
- WRITEBACK: mem_req_valid=1, we=1, addr={victim tag, index, 2'b00}, wdata=victim data.
  - On mem_req_ready, go to REFILL_REQ.
  - No memory response is expected for writes.
- REFILL_REQ: mem_req_valid=1, we=0, addr={req tag, index, 2'b00}. On mem_req_ready, go to REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid, update the victim way:
  - tag = req tag, valid = 1.
  - Load: data = mem_resp_rdata, dirty = 0.
  - Store: data = wdata, dirty = 1, and mem_resp_rdata is discarded.
  - Pulse lru_update_en with lru_new_mru_way = victim. Go to RESPOND.
- RESPOND: cpu_resp_valid=1 for exactly one cycle; rdata = line data (load) or wdata (store). Go to IDLE.
- Exactly one lru_update_en pulse per request.
- lru_index = latched index from LOOKUP through RESPOND; it equals cpu_req_addr index in IDLE.
- mem_resp_valid outside REFILL_WAIT is ignored.
- cpu_req_valid outside IDLE is ignored (ready=0).

## Timing
- Reset: state IDLE and all valid/dirty bits cleared.
  - Output reset values: cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_rdata=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, lru_update_en=0, lru_new_mru_way=0.
  - Data and tag arrays are not reset.
- Hit latency, with acceptance in cycle 0:
  - LOOKUP and lru_update_en in cycle 1.
  - cpu_resp_valid in cycle 2.
  - cpu_req_ready returns in cycle 3.
- Miss latency: memory handshake waits + memory response latency + 3 cycles, + 1 cycle if a writeback is needed.
- mem_req_valid/we/addr/wdata are stable while valid && !ready; valid never drops before ready.
- Reset mid-operation (any state) aborts immediately:
  - mem_req_valid drops asynchronously.
  - No response is issued; the in-flight line is not installed.
- Back-to-back requests: a new request can be accepted the cycle after RESPOND.

## Test plan
- Reset, then load 0x100 (cold miss): mem read to 0x100, return 0xDEADBEEF -> cpu_resp_rdata=0xDEADBEEF, lru_update_en with new_mru_way=0, no writeback.
- Repeat load 0x100 -> hit: resp at cycle 2 with 0xDEADBEEF, no mem_req_valid, lru_update_en with new_mru_way=0.
- Fill set 0x40 via 0x100 then 0x300 (ways 0, 1), reload 0x100, then load 0x500 -> lru_victim_way=1, way 1 replaced, mem read to 0x500 only.
- Store 0x1234 to 0x100 (hit, dirty), access 0x300, then load 0x500 -> writeback we=1, addr 0x100, wdata 0x1234, then read to 0x500.
- mem_req_ready held low for 5 cycles in WRITEBACK and in REFILL_REQ -> request fields stable; exactly one handshake each.
- rst_n asserted in REFILL_WAIT -> all outputs at reset values; reload of the same address misses (valid cleared); no spurious cpu_resp_valid.
